// File: rtl/button_debounce.sv
// Push-button conditioner: synchronizes a bouncing pin, debounces it and derives
// press/release/long-press pulses plus an LED toggle, all from one shared counter.
module button_debounce #(
  parameter logic [26:0] DEBOUNCE_CYCLES = 27'd1_000_000,
  parameter logic [26:0] LONG_CYCLES     = 27'd100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic btn_toggle
);

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    HELD_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  state_t      state;
  logic        sync_a;
  logic        sync_b;
  logic        long_done;
  logic [26:0] counter;

  // Two-flop synchronizer; only sync_b is allowed to reach the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= btn_in;
      sync_b <= sync_a;
    end
  end

  // Debounce and long-press FSM; pulses clear by default every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE_LOW;
      counter     <= 27'd0;
      long_done   <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      btn_toggle  <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
      case (state)
        IDLE_LOW: begin
          if (sync_b) begin
            state   <= WAIT_HIGH;
            counter <= 27'd0;
          end else begin
            state <= IDLE_LOW;
          end
        end
        WAIT_HIGH: begin
          if (!sync_b) begin
            state   <= IDLE_LOW;
            counter <= 27'd0;
          end else if (counter == DEBOUNCE_CYCLES - 27'd1) begin
            state      <= HELD_HIGH;
            counter    <= 27'd0;
            btn_level  <= 1'b1;
            btn_press  <= 1'b1;
            btn_toggle <= ~btn_toggle;
            long_done  <= 1'b0;
          end else begin
            counter <= counter + 27'd1;
          end
        end
        HELD_HIGH: begin
          if (!sync_b) begin
            state   <= WAIT_LOW;
            counter <= 27'd0;
          end else begin
            // Counter saturates so a very long hold cannot wrap into a second long pulse.
            if (counter != LONG_CYCLES - 27'd1) begin
              counter <= counter + 27'd1;
            end else begin
              counter <= counter;
            end
            if ((counter == LONG_CYCLES - 27'd1) && !long_done) begin
              btn_long  <= 1'b1;
              long_done <= 1'b1;
            end else begin
              long_done <= long_done;
            end
          end
        end
        WAIT_LOW: begin
          if (sync_b) begin
            state   <= HELD_HIGH;
            counter <= 27'd0;
          end else if (counter == DEBOUNCE_CYCLES - 27'd1) begin
            state       <= IDLE_LOW;
            counter     <= 27'd0;
            btn_level   <= 1'b0;
            btn_release <= 1'b1;
          end else begin
            counter <= counter + 27'd1;
          end
        end
        default: begin
          state   <= IDLE_LOW;
          counter <= 27'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 27'd1_000_000: stable-sample count (10 ms at 100 MHz) before a level change is accepted.
REQ-002 Parameter LONG_CYCLES, default 27'd100_000_000: held-high count (1 s at 100 MHz) before btn_long fires.
REQ-003 clk  input  1  single system clock, 100 MHz nominal; all flops on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset; clears every flop immediately.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing push-button pin; active-high.
REQ-006 btn_level  output  1  debounced button level, registered.
REQ-007 btn_press  output  1  one-cycle pulse on accepted low->high transition.
REQ-008 btn_release  output  1  one-cycle pulse on accepted high->low transition.
REQ-009 btn_long  output  1  one-cycle pulse once per press when held LONG_CYCLES.
REQ-010 btn_toggle  output  1  registered state that inverts on every btn_press; directly drives an LED.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer (sync_a, sync_b) before any use; only sync_b feeds logic.
REQ-012 One 27-bit counter SHALL serve both debounce and long-press timing; DEBOUNCE_CYCLES >= 2, LONG_CYCLES > DEBOUNCE_CYCLES, both <= 2^27-1.
REQ-013 FSM states SHALL be IDLE_LOW, WAIT_HIGH, HELD_HIGH, WAIT_LOW.
REQ-014 IDLE_LOW: sync_b=1 -> WAIT_HIGH, counter<=0; else stay.
REQ-015 WAIT_HIGH: sync_b=0 -> IDLE_LOW, counter<=0, no pulse; sync_b=1 and counter==DEBOUNCE_CYCLES-1 -> HELD_HIGH, counter<=0, btn_level<=1, btn_press<=1, btn_toggle<=~btn_toggle, long_done<=0; else counter+1.
REQ-016 HELD_HIGH: sync_b=0 -> WAIT_LOW, counter<=0; else counter increments, saturating at LONG_CYCLES-1.
REQ-017 HELD_HIGH: counter==LONG_CYCLES-1 and long_done=0 and sync_b=1 -> btn_long<=1, long_done<=1; btn_long SHALL never fire twice within one accepted press.
REQ-018 WAIT_LOW: sync_b=1 -> HELD_HIGH, counter<=0, no pulse, long_done unchanged; sync_b=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE_LOW, counter<=0, btn_level<=0, btn_release<=1; else counter+1.
REQ-019 btn_press, btn_release, btn_long SHALL each be high exactly one clock and SHALL default to 0 every other cycle.
REQ-020 Latency: with btn_in stably high, btn_press SHALL be registered on rising edge DEBOUNCE_CYCLES+3 counted from the first edge sampling btn_in=1; release is symmetric.
REQ-021 A bounce shorter than DEBOUNCE_CYCLES consecutive stable samples SHALL produce no output change.
REQ-022 btn_press and btn_release SHALL never assert in the same cycle; btn_long and btn_press SHALL never assert in the same cycle.

Reset
REQ-023 While reset=1: sync_a, sync_b, btn_level, btn_press, btn_release, btn_long, btn_toggle, long_done, counter = 0; state = IDLE_LOW.
REQ-024 Reset mid-operation (any state, any count) SHALL abort without emitting a pulse; if btn_in is high after deassertion, a fresh full debounce SHALL run and btn_press SHALL then fire normally.
REQ-025 No pulse output SHALL assert in the first cycle after reset deassertion.

Verification (DEBOUNCE_CYCLES=4, LONG_CYCLES=16)
REQ-026 btn_in 0->1 held -> btn_press high one cycle, registered on edge 7; btn_level=1 and btn_toggle=1 from then.
REQ-027 btn_in pulses high for 3 cycles then low -> btn_press, btn_level, btn_toggle all stay 0.
REQ-028 Press held 40 cycles -> exactly one btn_long pulse, 16 cycles after btn_press; then release -> one btn_release, btn_level=0.
REQ-029 While held, btn_in drops low 2 cycles then returns high -> no btn_release, no second btn_press, no second btn_long.
REQ-030 Two complete accepted presses -> btn_toggle returns to 0; two btn_press and two btn_release pulses counted.
REQ-031 reset asserted during WAIT_HIGH at count 2 with btn_in held high -> all outputs 0 immediately; after deassertion, btn_press registered on edge 7.
